// File: rtl/game_timer_pkg.sv
// Shared types and constants for the defuse-game match timer.
package game_timer_pkg;

  localparam int BCD_W   = 4;
  localparam int NDIG    = 6;
  localparam int MOD_DEC = 10;
  localparam int MOD_SIX = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_WON     = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  // Whole seconds represented by the M:SS digits.
  function automatic logic [9:0] bcd_secs(input logic [BCD_W-1:0] m,
                                          input logic [BCD_W-1:0] t,
                                          input logic [BCD_W-1:0] u);
    return 10'(m) * 10'd60 + 10'(t) * 10'd10 + 10'(u);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer chain: counts up or down modulo MOD with a
// synchronous load and a carry/borrow output for the next digit.
module bcd_digit
  import game_timer_pkg::*;
#(
  parameter int               MOD     = 10,
  parameter logic [BCD_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] q,
  output logic             co,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [BCD_W-1:0] MAXV = BCD_W'(MOD - 1);

  assign at_min = (q == '0);
  assign at_max = (q == MAXV);
  assign co     = en & (up ? at_max : at_min);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      if (up) q <= at_max ? '0 : q + 1'b1;
      else    q <= at_min ? MAXV : q - 1'b1;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Match timer: M:SS.mmm BCD chain with pause, penalty seconds, low-time warning
// and registered expiry. Digit index 0 is ms units, 5 is minutes.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int START_MIN   = 2,
  parameter int START_SEC   = 59,
  parameter int COUNT_UP    = 0,
  parameter int PENALTY_SEC = 10,
  parameter int WARN_SEC    = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             game_won,
  input  logic             penalty,
  input  logic             tick_1ms,
  output logic [BCD_W-1:0] min_unidade,
  output logic [BCD_W-1:0] seg_dezena,
  output logic [BCD_W-1:0] seg_unidade,
  output logic [BCD_W-1:0] ms_decimos,
  output logic             running,
  output logic             time_warn,
  output logic             penalty_busy,
  output logic             time_over,
  output state_t           dbg_state
);

  localparam bit UP        = (COUNT_UP != 0);
  localparam int LIMIT_SEC = START_MIN * 60 + START_SEC;

  localparam logic [BCD_W-1:0] P_MIN = BCD_W'(START_MIN);
  localparam logic [BCD_W-1:0] P_ST  = BCD_W'(START_SEC / 10);
  localparam logic [BCD_W-1:0] P_SU  = BCD_W'(START_SEC % 10);

  localparam logic [NDIG-1:0][BCD_W-1:0] LIMIT_V  = {P_MIN, P_ST, P_SU, 12'h000};
  localparam logic [NDIG-1:0][BCD_W-1:0] PRESET_V = UP ? '0 : {P_MIN, P_ST, P_SU, 12'h999};
  localparam logic [NDIG-1:0][BCD_W-1:0] TERM_V   = UP ? LIMIT_V : '0;

  state_t state_q, state_d;

  logic [NDIG-1:0][BCD_W-1:0] dig;
  logic [NDIG-1:0][BCD_W-1:0] load_val_v;
  logic [NDIG-1:0] en_v, co_v, dig_min, dig_max;
  logic [5:0]      pen_cnt;
  logic [6:0]      pen_sum;
  logic            tick_pend;
  logic            active, restart, pen_step, ms_step;
  logic            tick_term, pen_term, term_evt, load_any;
  logic            ms_zero, warn_cmp, warn_d;
  logic [9:0]      sec_total;

  assign active   = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign restart  = start && (((state_q == ST_WON) && !game_won) || (state_q == ST_EXPIRED));
  assign pen_step = active && (pen_cnt != '0) && !game_won;
  // A penalty step owns the seconds digit this cycle; the ms tick waits.
  assign ms_step  = (state_q == ST_RUN) && !game_won && !pen_step && (tick_1ms || tick_pend);

  assign sec_total = bcd_secs(dig[5], dig[4], dig[3]);
  assign ms_zero   = &dig_min[2:0];

  // Terminal detection stops the chain at the limit instead of wrapping.
  always_comb begin
    tick_term = 1'b0;
    pen_term  = 1'b0;
    if (UP) begin
      tick_term = ms_step && (((int'(sec_total) == LIMIT_SEC - 1) && (&dig_max[2:0])) || (&dig_max));
      pen_term  = pen_step && (int'(sec_total) + 1 >= LIMIT_SEC);
    end else begin
      tick_term = ms_step && (&dig_min[5:3]) && (dig[2:0] == 12'h001);
      pen_term  = pen_step && (co_v[5] || ((sec_total == 10'd1) && ms_zero));
    end
  end

  assign term_evt   = tick_term || pen_term;
  assign load_any   = restart || term_evt;
  assign load_val_v = restart ? PRESET_V : TERM_V;
  assign en_v       = {co_v[4], co_v[3], co_v[2] | pen_step, co_v[1], co_v[0], ms_step};

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit #(
      .MOD     ((i == 4) ? MOD_SIX : MOD_DEC),
      .RST_VAL (PRESET_V[i])
    ) u_digit (
      .clk      (clk),
      .reset    (reset),
      .en       (en_v[i]),
      .up       (UP),
      .load     (load_any),
      .load_val (load_val_v[i]),
      .q        (dig[i]),
      .co       (co_v[i]),
      .at_min   (dig_min[i]),
      .at_max   (dig_max[i])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (game_won)   state_d = ST_WON;
        else if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (game_won)      state_d = ST_WON;
        else if (term_evt) state_d = ST_EXPIRED;
        else if (pause)    state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (game_won)            state_d = ST_WON;
        else if (term_evt)       state_d = ST_EXPIRED;
        else if (start || pause) state_d = ST_RUN;
      end
      ST_WON:     if (restart) state_d = ST_IDLE;
      ST_EXPIRED: if (restart) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pen_sum = {1'b0, pen_cnt} - {6'd0, pen_step};
    if (penalty && active) pen_sum = pen_sum + 7'(PENALTY_SEC);
  end

  always_comb begin
    if (UP) warn_cmp = (LIMIT_SEC - int'(sec_total) < WARN_SEC) ||
                       ((LIMIT_SEC - int'(sec_total) == WARN_SEC) && !ms_zero);
    else    warn_cmp = int'(sec_total) < WARN_SEC;
    warn_d = (WARN_SEC != 0) && warn_cmp && (state_d != ST_IDLE) && (state_d != ST_WON);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pen_cnt   <= '0;
      tick_pend <= 1'b0;
      time_over <= 1'b0;
      time_warn <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_over <= (state_d == ST_EXPIRED);
      time_warn <= warn_d;
      if (!active || game_won || term_evt) pen_cnt <= '0;
      else if (pen_sum > 7'd63)            pen_cnt <= 6'd63;
      else                                 pen_cnt <= pen_sum[5:0];
      // One-deep tick buffer: a tick landing on a penalty step is replayed later.
      if ((state_q != ST_RUN) || game_won || term_evt) tick_pend <= 1'b0;
      else if (pen_step)                               tick_pend <= tick_pend | tick_1ms;
      else if (ms_step)                                tick_pend <= tick_pend & tick_1ms;
    end
  end

  assign min_unidade  = dig[5];
  assign seg_dezena   = dig[4];
  assign seg_unidade  = dig[3];
  assign ms_decimos   = dig[2];
  assign running      = (state_q == ST_RUN);
  assign penalty_busy = (pen_cnt != '0);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: a count-down instance with default presets and
// a count-up instance (limit 0:03, warning at 2 s), checked through an expected queue.
module tb_game_timer;
  import game_timer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic d_start = 0, d_pause = 0, d_game_won = 0, d_penalty = 0, d_tick = 0;
  logic [3:0] d_min, d_st, d_su, d_dec;
  logic d_running, d_time_warn, d_penalty_busy, d_time_over;
  state_t d_state;

  logic u_start = 0, u_game_won = 0, u_tick = 0;
  logic [3:0] u_min, u_st, u_su, u_dec;
  logic u_running, u_time_warn, u_penalty_busy, u_time_over;
  state_t u_state;

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_timer dut_down (
    .clk(clk), .reset(reset), .start(d_start), .pause(d_pause), .game_won(d_game_won),
    .penalty(d_penalty), .tick_1ms(d_tick), .min_unidade(d_min), .seg_dezena(d_st),
    .seg_unidade(d_su), .ms_decimos(d_dec), .running(d_running), .time_warn(d_time_warn),
    .penalty_busy(d_penalty_busy), .time_over(d_time_over), .dbg_state(d_state)
  );

  game_timer #(
    .START_MIN(0), .START_SEC(3), .COUNT_UP(1), .PENALTY_SEC(10), .WARN_SEC(2)
  ) dut_up (
    .clk(clk), .reset(reset), .start(u_start), .pause(1'b0), .game_won(u_game_won),
    .penalty(1'b0), .tick_1ms(u_tick), .min_unidade(u_min), .seg_dezena(u_st),
    .seg_unidade(u_su), .ms_decimos(u_dec), .running(u_running), .time_warn(u_time_warn),
    .penalty_busy(u_penalty_busy), .time_over(u_time_over), .dbg_state(u_state)
  );

  function automatic logic [15:0] fl(input state_t s, input logic o, input logic w,
                                     input logic b, input logic r);
    return {9'd0, s, o, w, b, r};
  endfunction

  function automatic logic [15:0] d_digits();
    return {d_min, d_st, d_su, d_dec};
  endfunction
  function automatic logic [15:0] d_flags();
    return {9'd0, d_state, d_time_over, d_time_warn, d_penalty_busy, d_running};
  endfunction
  function automatic logic [15:0] u_digits();
    return {u_min, u_st, u_su, u_dec};
  endfunction
  function automatic logic [15:0] u_flags();
    return {9'd0, u_state, u_time_over, u_time_warn, u_penalty_busy, u_running};
  endfunction

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h but scoreboard queue is empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 start, 1 pause, 2 penalty, 3 game_won; held for len clocks
  task automatic d_pulse(input int which, input int len);
    case (which)
      0: d_start = 1'b1;
      1: d_pause = 1'b1;
      2: d_penalty = 1'b1;
      default: d_game_won = 1'b1;
    endcase
    cyc(len);
    d_start = 1'b0; d_pause = 1'b0; d_penalty = 1'b0; d_game_won = 1'b0;
  endtask

  task automatic d_ticks(input int n);
    d_tick = 1'b1;
    cyc(n);
    d_tick = 1'b0;
  endtask

  task automatic d_pen_spaced(input int n);
    for (int i = 0; i < n; i++) begin
      d_pulse(2, 1);
      cyc(11);
    end
  endtask

  task automatic u_ticks(input int n);
    u_tick = 1'b1;
    cyc(n);
    u_tick = 1'b0;
  endtask

  task automatic u_start_pulse();
    u_start = 1'b1;
    cyc(1);
    u_start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ---- count-down instance ----
    push(16'h2599);                    check("d_reset_digits", d_digits());
    push(fl(ST_IDLE, 0, 0, 0, 0));     check("d_reset_flags", d_flags());
    d_ticks(5);
    push(16'h2599);                    check("d_idle_ignores_ticks", d_digits());
    d_pulse(0, 1);
    push(fl(ST_RUN, 0, 0, 0, 1));      check("d_start_run", d_flags());
    d_ticks(1000);
    push(16'h2589);                    check("d_1000_ticks", d_digits());

    d_pulse(1, 1);
    push(fl(ST_PAUSED, 0, 0, 0, 0));   check("d_paused_flags", d_flags());
    d_ticks(500);
    push(16'h2589);                    check("d_paused_hold", d_digits());
    d_pulse(1, 1);
    d_ticks(100);
    push(16'h2588);                    check("d_resume_counts", d_digits());
    d_ticks(99);

    // penalty at 2:58.800 with two ticks landing on steps: only one survives
    d_pulse(2, 1);
    push(fl(ST_RUN, 0, 0, 1, 1));      check("d_penalty_busy", d_flags());
    d_ticks(2);
    cyc(10);
    push(16'h2487);                    check("d_penalty_tick_pend", d_digits());
    push(fl(ST_RUN, 0, 0, 0, 1));      check("d_penalty_done", d_flags());
    d_ticks(99);
    push(16'h2487);                    check("d_second_tick_dropped", d_digits());
    d_ticks(1);
    push(16'h2486);                    check("d_after_drop_step", d_digits());

    d_pen_spaced(10);
    push(16'h1086);                    check("d_ten_penalties", d_digits());
    d_ticks(3000);
    push(16'h1056);                    check("d_at_1_05", d_digits());
    d_pulse(2, 1);
    cyc(11);
    push(16'h0556);                    check("d_penalty_min_borrow", d_digits());
    push(fl(ST_RUN, 0, 0, 0, 1));      check("d_no_warn_55s", d_flags());

    d_pulse(2, 5);
    cyc(55);
    push(16'h0056);                    check("d_penalty_accumulate", d_digits());
    push(fl(ST_RUN, 0, 1, 0, 1));      check("d_warn_5s", d_flags());
    d_ticks(300);
    push(16'h0053);                    check("d_at_0_05_3", d_digits());
    d_pulse(2, 1);
    cyc(8);
    push(16'h0000);                    check("d_penalty_saturate", d_digits());
    push(fl(ST_EXPIRED, 1, 1, 0, 0));  check("d_penalty_expire", d_flags());
    d_ticks(5);
    push(16'h0000);                    check("d_expired_hold", d_digits());

    d_pulse(0, 1);
    push(16'h2599);                    check("d_restart_digits", d_digits());
    push(fl(ST_IDLE, 0, 0, 0, 0));     check("d_restart_flags", d_flags());
    d_pulse(0, 1);
    d_ticks(1000);
    push(16'h2589);                    check("d_rerun_1000", d_digits());
    d_pulse(2, 7);
    cyc(70);
    push(16'h1499);                    check("d_pen_cnt_sat63", d_digits());
    push(fl(ST_RUN, 0, 0, 0, 1));      check("d_sat_done", d_flags());
    d_pen_spaced(10);
    push(16'h0099);                    check("d_at_0_09", d_digits());
    d_ticks(9998);
    push(16'h0000);                    check("d_at_0_00_001", d_digits());
    push(fl(ST_RUN, 0, 1, 0, 1));      check("d_not_yet_over", d_flags());
    d_ticks(1);
    push(fl(ST_EXPIRED, 1, 1, 0, 0));  check("d_time_over_latency", d_flags());
    d_ticks(3);
    push(16'h0000);                    check("d_final_hold", d_digits());

    // ---- count-up instance ----
    push(16'h0000);                    check("u_reset_digits", u_digits());
    push(fl(ST_IDLE, 0, 0, 0, 0));     check("u_reset_flags", u_flags());
    u_start_pulse();
    u_ticks(1000);
    push(16'h0010);                    check("u_1000_ticks", u_digits());
    cyc(1);
    push(fl(ST_RUN, 0, 0, 0, 1));      check("u_warn_edge_off", u_flags());
    u_ticks(500);
    push(16'h0015);                    check("u_1500_ticks", u_digits());
    cyc(1);
    push(fl(ST_RUN, 0, 1, 0, 1));      check("u_warn_on", u_flags());
    u_ticks(1499);
    push(16'h0029);                    check("u_at_2_999", u_digits());
    u_tick = 1'b1; u_game_won = 1'b1;
    cyc(1);
    u_tick = 1'b0; u_game_won = 1'b0;
    push(fl(ST_WON, 0, 0, 0, 0));      check("u_won_beats_terminal", u_flags());
    push(16'h0029);                    check("u_won_frozen", u_digits());
    u_start_pulse();
    push(16'h0000);                    check("u_restart_digits", u_digits());
    push(fl(ST_IDLE, 0, 0, 0, 0));     check("u_restart_flags", u_flags());
    u_start_pulse();
    u_ticks(2999);
    push(fl(ST_RUN, 0, 1, 0, 1));      check("u_before_limit", u_flags());
    u_ticks(1);
    push(16'h0030);                    check("u_limit_digits", u_digits());
    push(fl(ST_EXPIRED, 1, 1, 0, 0));  check("u_limit_expire", u_flags());
    u_ticks(2);
    push(16'h0030);                    check("u_limit_hold", u_digits());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
